// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between NUM_REQ requesters (port 0 = host
//   loader). One transaction in flight at a time; the arbiter owns the memory
//   address, write data and write enable, and returns read data plus a
//   one-cycle completion pulse to the port that issued the access.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   req_valid/we         per-port request and direction (1 = write)
//   req_addr/req_wdata   per-port fields, port i at [i*W +: W]
//   req_ready            one-hot accept, only while idle
//   rsp_valid/rsp_rdata  completion pulse to owner, read data (held between reads)
//   mem_addr/wdata/we    to the memory
//   mem_rdata            from the memory, sampled READ_LAT edges after the address
//   busy                 transaction in flight
//   grant_id             index of the current/last owner
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned HOST_PRIO = 1,
  localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT} state_t;

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q,    mem_we_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ID_W-1:0]     grant_id_q,  grant_id_d;
  logic [ID_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [LAT_W-1:0]    lat_cnt_q,   lat_cnt_d;

  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic [ID_W-1:0]     cand;

  function automatic logic [ID_W-1:0] wrap_idx(input int unsigned k);
    return ID_W'(k % NUM_REQ);
  endfunction

  // Winner: host port first when prioritised, otherwise first valid port
  // scanning upward from the port after the last grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (HOST_PRIO != 0 && req_valid[0]) begin
      win_found = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand = wrap_idx(32'(rr_ptr_q) + i + 1);
        if (!win_found && req_valid[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && win_found) begin
      req_ready = NUM_REQ'(1) << win_idx;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    lat_cnt_d   = lat_cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_we_d    = 1'b0;
    rsp_valid_d = '0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          mem_addr_d  = req_addr[win_idx*ADDR_W +: ADDR_W];
          mem_wdata_d = req_wdata[win_idx*DATA_W +: DATA_W];
          grant_id_d  = win_idx;
          rr_ptr_d    = win_idx;
          if (req_we[win_idx]) begin
            mem_we_d = 1'b1;
            state_d  = WRITE;
          end else begin
            lat_cnt_d = LAT_W'(READ_LAT - 1);
            state_d   = READ_WAIT;
          end
        end
      end
      WRITE: begin
        rsp_valid_d = NUM_REQ'(1) << grant_id_q;
        state_d     = IDLE;
      end
      READ_WAIT: begin
        if (lat_cnt_q == '0) begin
          rsp_rdata_d = mem_rdata;
          rsp_valid_d = NUM_REQ'(1) << grant_id_q;
          state_d     = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      grant_id_q  <= '0;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      lat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end

  always_comb begin
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_we    = mem_we_q;
    rsp_valid = rsp_valid_q;
    rsp_rdata = rsp_rdata_q;
    grant_id  = grant_id_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 with host priority, instance 1 pure
// round-robin, each with its own registered memory (one-edge read).
module tb_mem_port_arbiter;
  localparam int NR = 3;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int RL = 2;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid [2];
  logic [NR-1:0]    req_we    [2];
  logic [NR*AW-1:0] req_addr  [2];
  logic [NR*DW-1:0] req_wdata [2];
  logic [NR-1:0]    req_ready [2];
  logic [NR-1:0]    rsp_valid [2];
  logic [DW-1:0]    rsp_rdata [2];
  logic [AW-1:0]    mem_addr  [2];
  logic [DW-1:0]    mem_wdata [2];
  logic             mem_we    [2];
  logic [DW-1:0]    mem_rdata [2];
  logic             busy      [2];
  logic [IW-1:0]    grant_id  [2];

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .HOST_PRIO(1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0]), .grant_id(grant_id[0]));

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .HOST_PRIO(0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1]), .grant_id(grant_id[1]));

  function automatic logic [7:0] init_val(input int a);
    logic [7:0] v;
    v = 8'(a) ^ 8'hC3;
    if (a == 5) v = 8'h20;
    return v;
  endfunction

  // Memories: address registered by the arbiter, data registered here.
  logic [7:0] tm0 [256];
  logic [7:0] tm1 [256];
  bit         wr0 [256];
  bit         wr1 [256];
  always @(posedge clk) begin
    mem_rdata[0] <= wr0[mem_addr[0]] ? tm0[mem_addr[0]] : init_val(int'(mem_addr[0]));
    mem_rdata[1] <= wr1[mem_addr[1]] ? tm1[mem_addr[1]] : init_val(int'(mem_addr[1]));
    if (mem_we[0]) begin tm0[mem_addr[0]] <= mem_wdata[0]; wr0[mem_addr[0]] <= 1'b1; end
    if (mem_we[1]) begin tm1[mem_addr[1]] <= mem_wdata[1]; wr1[mem_addr[1]] <= 1'b1; end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model: an access occupies the memory for a fixed
  // number of edges (1 for writes, RL for reads) then completes.
  int             m_rem [2];
  int             m_rr  [2];
  int             m_own [2];
  bit             m_isw [2];
  logic [7:0]     e_addr [2];
  logic [7:0]     e_wdata [2];
  logic [7:0]     e_rdata [2];
  logic [NR-1:0]  e_rsp [2];
  logic           e_we [2];
  logic [IW-1:0]  e_gid [2];
  logic [7:0]     shadow [2][256];

  function automatic int winner(input int k, input logic [NR-1:0] v, input int rr);
    if (k == 0 && v[0]) return 0;
    for (int off = 1; off <= NR; off++) begin
      int p;
      p = (rr + off) % NR;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_rr[k] = NR - 1; m_own[k] = 0; m_isw[k] = 1'b0;
      e_addr[k] = '0; e_wdata[k] = '0; e_rdata[k] = '0; e_rsp[k] = '0; e_we[k] = 1'b0; e_gid[k] = '0;
      for (int a = 0; a < 256; a++) shadow[k][a] = init_val(a);
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_rem[k] = 0; m_rr[k] = NR - 1; m_own[k] = 0;
          e_addr[k] = '0; e_wdata[k] = '0; e_rdata[k] = '0; e_rsp[k] = '0; e_we[k] = 1'b0; e_gid[k] = '0;
        end else begin
          int w;
          e_rsp[k] = '0;
          e_we[k]  = 1'b0;
          if (m_rem[k] > 0) begin
            m_rem[k]--;
            if (m_rem[k] == 0) begin
              e_rsp[k] = NR'(1) << m_own[k];
              if (m_isw[k]) shadow[k][e_addr[k]] = e_wdata[k];
              else e_rdata[k] = shadow[k][e_addr[k]];
            end
          end else begin
            w = winner(k, req_valid[k], m_rr[k]);
            if (w >= 0) begin
              m_own[k]   = w;
              m_rr[k]    = w;
              e_gid[k]   = IW'(w);
              e_addr[k]  = req_addr[k][w*AW +: AW];
              e_wdata[k] = req_wdata[k][w*DW +: DW];
              m_isw[k]   = req_we[k][w];
              e_we[k]    = req_we[k][w];
              m_rem[k]   = req_we[k][w] ? 1 : RL;
            end
          end
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc=%0d actual=%0h expected=%0h", name, k, cyc, act, exp);
    end
  endtask

  // Observation log filled once per cycle.
  bit   hold [2][NR];
  int   acc_edge [2][NR];
  int   rsp_edge [2][NR];
  int   rsp_cnt  [2][NR];
  logic [7:0] rsp_dat [2][NR];
  int   we_cnt  [2];
  logic [7:0] we_addr [2];
  int   gq0 [$];
  int   gq1 [$];
  int   ge1 [$];

  // One cycle: compare against the model at the falling edge, log
  // accepts/responses, then retire accepted non-held requests after the edge.
  task automatic tick();
    logic [NR-1:0] acc [2];
    logic [NR-1:0] exp_rdy;
    int w;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      w = winner(k, req_valid[k], m_rr[k]);
      exp_rdy = (!rst && m_rem[k] == 0 && w >= 0) ? (NR'(1) << w) : '0;
      chk("req_ready", k, 32'(req_ready[k]), 32'(exp_rdy));
      chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(e_rsp[k]));
      chk("rsp_rdata", k, 32'(rsp_rdata[k]), 32'(e_rdata[k]));
      chk("mem_addr",  k, 32'(mem_addr[k]),  32'(e_addr[k]));
      chk("mem_wdata", k, 32'(mem_wdata[k]), 32'(e_wdata[k]));
      chk("mem_we",    k, 32'(mem_we[k]),    32'(e_we[k]));
      chk("busy",      k, 32'(busy[k]),      32'(m_rem[k] != 0));
      chk("grant_id",  k, 32'(grant_id[k]),  32'(e_gid[k]));
      acc[k] = req_valid[k] & req_ready[k];
      for (int p = 0; p < NR; p++) begin
        if (acc[k][p]) begin
          acc_edge[k][p] = cyc + 1;
          if (k == 0) gq0.push_back(p);
          else begin gq1.push_back(p); ge1.push_back(cyc + 1); end
        end
        if (rsp_valid[k][p]) begin
          rsp_edge[k][p] = cyc;
          rsp_dat[k][p]  = rsp_rdata[k];
          rsp_cnt[k][p]++;
        end
      end
      if (mem_we[k]) begin we_cnt[k]++; we_addr[k] = mem_addr[k]; end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NR; p++)
        if (acc[k][p] && !hold[k][p]) req_valid[k][p] = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input int k, input int p, input bit we, input logic [7:0] a, input logic [7:0] d);
    req_valid[k][p] = 1'b1;
    req_we[k][p]    = we;
    req_addr[k][p*AW +: AW]  = a;
    req_wdata[k][p*DW +: DW] = d;
  endtask

  initial begin
    int t0;
    int rc;
    int wc;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = '0; req_we[k] = '0; req_addr[k] = '0; req_wdata[k] = '0;
      we_cnt[k] = 0; we_addr[k] = '0;
      for (int p = 0; p < NR; p++) begin
        hold[k][p] = 1'b0; acc_edge[k][p] = -1; rsp_edge[k][p] = -1; rsp_cnt[k][p] = 0; rsp_dat[k][p] = '0;
      end
    end
    ticks(3);
    rst = 1'b0;
    tick();
    chk("rst_busy", 0, 32'(busy[0]), 0);
    chk("rst_grant", 0, 32'(grant_id[0]), 0);
    chk("rst_rdata", 0, 32'(rsp_rdata[0]), 0);
    chk("rst_mem_addr", 1, 32'(mem_addr[1]), 0);

    // 1: port 1 read of 0x05 -> 0x20, response two edges after accept
    t0 = cyc;
    drive(0, 1, 1'b0, 8'h05, 8'h00);
    ticks(4);
    chk("t1_accept_edge", 0, 32'(acc_edge[0][1]), 32'(t0 + 1));
    chk("t1_rsp_edge", 0, 32'(rsp_edge[0][1]), 32'(t0 + 3));
    chk("t1_rdata", 0, 32'(rsp_dat[0][1]), 32'h20);

    // 2: port 0 write 0x10 <- 0xA5, then port 1 reads it back
    t0 = cyc;
    wc = we_cnt[0];
    drive(0, 0, 1'b1, 8'h10, 8'hA5);
    ticks(3);
    chk("t2_accept_edge", 0, 32'(acc_edge[0][0]), 32'(t0 + 1));
    chk("t2_rsp_edge", 0, 32'(rsp_edge[0][0]), 32'(t0 + 2));
    chk("t2_we_cycles", 0, 32'(we_cnt[0] - wc), 1);
    chk("t2_we_addr", 0, 32'(we_addr[0]), 32'h10);
    drive(0, 1, 1'b0, 8'h10, 8'h00);
    ticks(4);
    chk("t2_readback", 0, 32'(rsp_dat[0][1]), 32'hA5);

    // 6: port 1 waits while port 2 is served, accepted as rsp_valid[2] pulses
    t0 = cyc;
    drive(0, 2, 1'b0, 8'h30, 8'h00);
    tick();
    drive(0, 1, 1'b0, 8'h05, 8'h00);
    ticks(4);
    chk("t6_rsp2_edge", 0, 32'(rsp_edge[0][2]), 32'(t0 + 3));
    chk("t6_accept1_edge", 0, 32'(acc_edge[0][1]), 32'(t0 + 4));
    ticks(3);
    chk("t6_rdata1", 0, 32'(rsp_dat[0][1]), 32'h20);

    // 4: host priority, ports 0 and 2 together twice
    gq0.delete();
    t0 = cyc;
    drive(0, 0, 1'b0, 8'h11, 8'h00);
    drive(0, 2, 1'b0, 8'h12, 8'h00);
    tick();
    drive(0, 0, 1'b0, 8'h13, 8'h00);
    ticks(6);
    chk("t4_ngrants", 0, 32'(gq0.size()), 3);
    for (int i = 0; i < 3; i++)
      chk("t4_order", 0, (i < gq0.size()) ? 32'(gq0[i]) : 32'hFFFF_FFFF, (i < 2) ? 0 : 2);
    chk("t4_port2_edge", 0, 32'(acc_edge[0][2]), 32'(t0 + 7));
    ticks(3);

    // 3: pure round-robin, all three ports reading continuously
    gq1.delete();
    ge1.delete();
    for (int p = 0; p < NR; p++) begin
      hold[1][p] = 1'b1;
      drive(1, p, 1'b0, 8'(8'h20 + p), 8'h00);
    end
    ticks(18);
    for (int p = 0; p < NR; p++) begin
      hold[1][p] = 1'b0;
      req_valid[1][p] = 1'b0;
    end
    chk("t3_ngrants", 1, 32'(gq1.size()), 6);
    for (int i = 0; i < 6; i++)
      chk("t3_order", 1, (i < gq1.size()) ? 32'(gq1[i]) : 32'hFFFF_FFFF, 32'(i % 3));
    for (int i = 1; i < 6; i++)
      chk("t3_spacing", 1, (i < ge1.size()) ? 32'(ge1[i] - ge1[i-1]) : 32'hFFFF_FFFF, 3);
    ticks(2);

    // 5: reset one cycle after a port 2 read is accepted
    drive(1, 1, 1'b0, 8'h40, 8'h00);
    ticks(4);
    drive(0, 2, 1'b0, 8'h06, 8'h00);
    tick();
    rc = rsp_cnt[0][2];
    tick();
    rst = 1'b1;
    #1;
    chk("t5_busy", 0, 32'(busy[0]), 0);
    chk("t5_mem_addr", 0, 32'(mem_addr[0]), 0);
    chk("t5_rsp_valid", 0, 32'(rsp_valid[0]), 0);
    chk("t5_grant", 0, 32'(grant_id[0]), 0);
    ticks(2);
    rst = 1'b0;
    tick();
    chk("t5_no_rsp", 0, 32'(rsp_cnt[0][2]), 32'(rc));
    gq0.delete();
    gq1.delete();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NR; p++) drive(k, p, 1'b0, 8'(8'h50 + p), 8'h00);
    ticks(12);
    chk("t5_ngrants0", 0, 32'(gq0.size()), 3);
    chk("t5_ngrants1", 1, 32'(gq1.size()), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t5_order0", 0, (i < gq0.size()) ? 32'(gq0[i]) : 32'hFFFF_FFFF, 32'(i));
      chk("t5_order1", 1, (i < gq1.size()) ? 32'(gq1[i]) : 32'hFFFF_FFFF, 32'(i));
    end
    ticks(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
